// File: rtl/interrupt_dispatcher_if.sv
// Request side (from the input controller) and inject side (to fetch) of the
// interrupt dispatcher, plus its debug status.
interface interrupt_dispatcher_if #(
    parameter int DEPTH = 4
);
    logic [31:0]            interrupt_instruction;
    logic                   irq_valid;
    logic                   inject_ready;
    logic [31:0]            inject_instr;
    logic                   inject_valid;
    logic                   overflow;
    logic [$clog2(DEPTH):0] occupancy;

    modport master (
        output interrupt_instruction, irq_valid, inject_ready,
        input  inject_instr, inject_valid, overflow, occupancy
    );

    modport slave (
        input  interrupt_instruction, irq_valid, inject_ready,
        output inject_instr, inject_valid, overflow, occupancy
    );
endinterface

// File: rtl/interrupt_dispatcher.sv
// Queues interrupt instructions and injects them one at a time into fetch,
// holding a fixed idle gap after each accepted injection.
module interrupt_dispatcher #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 5,
    parameter bit COALESCE   = 1'b1
) (
    input logic                   sysclk,
    input logic                   reset,
    interrupt_dispatcher_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;
    state_t state, state_nxt;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] queued_after_pop;
    logic [GW-1:0] gap_cnt;
    logic [31:0]   instr_q;
    logic          overflow_q;
    logic          pop, push, load_gap, full, drop_full, drop_dup;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_gap  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.inject_ready) begin
                    if (GAP_CYCLES > 0) begin
                        load_gap  = 1'b1;
                        state_nxt = GAP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt <= GW'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The entry being popped moves to the presented slot, so it no longer
    // counts as a queued tail for coalescing.
    assign full             = (count == CW'(DEPTH));
    assign queued_after_pop = count - CW'(pop);
    assign drop_full        = full && !pop;
    assign drop_dup         = COALESCE && (queued_after_pop != '0) &&
                              (bus.interrupt_instruction == mem[wr_ptr - AW'(1)]);
    assign push             = bus.irq_valid && !drop_full && !drop_dup;

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            gap_cnt    <= '0;
            instr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                instr_q <= mem[rd_ptr];
            end
            if (load_gap)           gap_cnt <= GW'(GAP_CYCLES);
            else if (state == GAP)  gap_cnt <= gap_cnt - GW'(1);
            if (bus.irq_valid && drop_full) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset; only slots behind valid pointers are read.
    always_ff @(posedge sysclk) begin
        if (reset && push) mem[wr_ptr] <= bus.interrupt_instruction;
    end

    assign bus.inject_valid = (state == PRESENT);
    assign bus.inject_instr = instr_q;
    assign bus.overflow     = overflow_q;
    assign bus.occupancy    = count;
endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Directed bench for interrupt_dispatcher: a coalescing instance and a
// non-coalescing twin share the same stimulus.
module tb_interrupt_dispatcher;
    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    interrupt_dispatcher_if #(.DEPTH(4)) bus ();
    interrupt_dispatcher_if #(.DEPTH(4)) nc_bus ();

    assign nc_bus.interrupt_instruction = bus.interrupt_instruction;
    assign nc_bus.irq_valid             = bus.irq_valid;
    assign nc_bus.inject_ready          = bus.inject_ready;

    interrupt_dispatcher #(.DEPTH(4), .GAP_CYCLES(5), .COALESCE(1'b1)) u_dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    interrupt_dispatcher #(.DEPTH(4), .GAP_CYCLES(5), .COALESCE(1'b0)) u_nc (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (nc_bus)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [31:0] v);
        bus.irq_valid             = 1'b1;
        bus.interrupt_instruction = v;
        tick();
        bus.irq_valid             = 1'b0;
    endtask

    task automatic quick_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Ticks until inject_valid, then checks the latency and presented value.
    task automatic await_present(input string tag, input logic [31:0] exp, input int exp_lat);
        int n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (bus.inject_valid) break;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check(tag, bus.inject_instr, exp);
    endtask

    initial begin
        bus.irq_valid             = 1'b0;
        bus.interrupt_instruction = '0;
        bus.inject_ready          = 1'b0;

        // Reset held with requests strobing
        reset                     = 1'b0;
        bus.irq_valid             = 1'b1;
        bus.interrupt_instruction = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_valid%0d", i), 32'(bus.inject_valid), 32'd0);
            check($sformatf("rst_occ%0d", i),   32'(bus.occupancy),    32'd0);
            check($sformatf("rst_ovf%0d", i),   32'(bus.overflow),     32'd0);
        end
        check("rst_instr", bus.inject_instr, 32'd0);
        bus.irq_valid = 1'b0;
        reset         = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_rst_valid%0d", i), 32'(bus.inject_valid), 32'd0);
            check($sformatf("post_rst_occ%0d", i),   32'(bus.occupancy),    32'd0);
        end

        // Single request: present two cycles after the strobe, then gap
        bus.inject_ready = 1'b1;
        strobe(32'h0000_1337);
        check("single_c1_valid", 32'(bus.inject_valid), 32'd0);
        check("single_c1_occ",   32'(bus.occupancy),    32'd1);
        tick();
        check("single_c2_valid", 32'(bus.inject_valid), 32'd1);
        check("single_c2_instr", bus.inject_instr,      32'h0000_1337);
        check("single_c2_occ",   32'(bus.occupancy),    32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("single_gap%0d", i), 32'(bus.inject_valid), 32'd0);
        end

        // Backpressure: A held stable while B waits
        quick_reset();
        bus.inject_ready = 1'b0;
        strobe(32'hA);
        strobe(32'hB);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            check($sformatf("bp_hold_valid%0d", i), 32'(bus.inject_valid), 32'd1);
            check($sformatf("bp_hold_instr%0d", i), bus.inject_instr,      32'hA);
            check($sformatf("bp_hold_occ%0d", i),   32'(bus.occupancy),    32'd1);
        end
        bus.inject_ready = 1'b1;
        await_present("bp_b", 32'hB, 7);
        check("bp_b_occ", 32'(bus.occupancy), 32'd0);

        // Overflow: 1 presented, 2..5 queued, 6 lost
        quick_reset();
        bus.inject_ready = 1'b0;
        for (int v = 1; v <= 6; v++) strobe(32'(v));
        check("ovf_valid", 32'(bus.inject_valid), 32'd1);
        check("ovf_instr", bus.inject_instr,      32'd1);
        check("ovf_occ",   32'(bus.occupancy),    32'd4);
        check("ovf_flag",  32'(bus.overflow),     32'd1);
        bus.inject_ready = 1'b1;
        for (int v = 2; v <= 5; v++) await_present($sformatf("ovf_drain%0d", v), 32'(v), 7);
        for (int i = 0; i < 8; i++) tick();
        check("ovf_end_valid", 32'(bus.inject_valid), 32'd0);
        check("ovf_end_occ",   32'(bus.occupancy),    32'd0);
        check("ovf_sticky",    32'(bus.overflow),     32'd1);

        // Coalesce: 7,7,8,7 behind presented 1
        quick_reset();
        bus.inject_ready = 1'b0;
        strobe(32'h1);
        strobe(32'h7);
        strobe(32'h7);
        strobe(32'h8);
        strobe(32'h7);
        check("coal_instr",  bus.inject_instr,        32'h1);
        check("coal_occ",    32'(bus.occupancy),      32'd3);
        check("coal_ovf",    32'(bus.overflow),       32'd0);
        check("nocoal_occ",  32'(nc_bus.occupancy),   32'd4);
        check("nocoal_ovf",  32'(nc_bus.overflow),    32'd0);
        bus.inject_ready = 1'b1;
        await_present("coal_d0", 32'h7, 7);
        await_present("coal_d1", 32'h8, 7);
        await_present("coal_d2", 32'h7, 7);

        // Full FIFO with a write landing on the pop cycle
        quick_reset();
        bus.inject_ready = 1'b0;
        for (int v = 1; v <= 5; v++) strobe(32'(v));
        check("fp_occ_full", 32'(bus.occupancy), 32'd4);
        check("fp_ovf0",     32'(bus.overflow),  32'd0);
        bus.inject_ready = 1'b1;
        tick();
        bus.inject_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("fp_idle_valid", 32'(bus.inject_valid), 32'd0);
        check("fp_idle_occ",   32'(bus.occupancy),    32'd4);
        strobe(32'h6);
        check("fp_pop_valid", 32'(bus.inject_valid), 32'd1);
        check("fp_pop_instr", bus.inject_instr,      32'd2);
        check("fp_pop_occ",   32'(bus.occupancy),    32'd4);
        check("fp_pop_ovf",   32'(bus.overflow),     32'd0);
        bus.inject_ready = 1'b1;
        for (int v = 3; v <= 6; v++) await_present($sformatf("fp_drain%0d", v), 32'(v), 7);
        check("fp_end_ovf", 32'(bus.overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
